// File: rtl/mac_array_ctrl.sv
// Pass sequencer for the chained mac_row array: streams kernel then activation
// vectors from SRAM into the L0 FIFO and counts south-edge outputs to detect completion.
module mac_array_ctrl #(
  parameter int col     = 8,
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  input  logic [addr_bw-1:0] x_len,
  input  logic               l0_full,
  input  logic               out_valid,
  output logic               mem_cen,
  output logic [addr_bw-1:0] mem_addr,
  output logic               l0_wr,
  output logic [1:0]         inst_w,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {IDLE, LOAD_W, GAP, EXEC, DRAIN, DONE} state_t;

  state_t             state_reg;
  logic [addr_bw-1:0] w_base_reg;
  logic [addr_bw-1:0] x_base_reg;
  logic [addr_bw-1:0] x_len_reg;
  logic [addr_bw-1:0] rd_cnt_reg;
  logic [addr_bw-1:0] out_cnt_reg;
  logic [addr_bw-1:0] out_cnt_next;
  logic               l0_wr_reg;
  logic [1:0]         inst_w_reg;
  logic               rd_phase;
  logic               rd_issue;
  logic               out_count_en;

  // Read enable follows l0_full in the same cycle, so a stalled slot never reaches SRAM.
  assign rd_phase = (state_reg == LOAD_W) || (state_reg == EXEC);
  assign rd_issue = rd_phase && !l0_full;
  assign mem_cen  = ~rd_issue;

  always_comb begin
    mem_addr = '0;
    if (state_reg == LOAD_W)
      mem_addr = w_base_reg + rd_cnt_reg;
    else if (state_reg == EXEC)
      mem_addr = x_base_reg + rd_cnt_reg;
  end

  // Outputs may overtake the tail of EXEC; the count saturates at x_len.
  assign out_count_en = ((state_reg == EXEC) || (state_reg == DRAIN)) &&
                        out_valid && (out_cnt_reg != x_len_reg);
  assign out_cnt_next = out_count_en ? out_cnt_reg + addr_bw'(1) : out_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      w_base_reg  <= '0;
      x_base_reg  <= '0;
      x_len_reg   <= '0;
      rd_cnt_reg  <= '0;
      out_cnt_reg <= '0;
      l0_wr_reg   <= 1'b0;
      inst_w_reg  <= 2'b00;
    end else begin
      l0_wr_reg   <= rd_issue;
      inst_w_reg  <= !rd_issue ? 2'b00 : (state_reg == LOAD_W) ? 2'b01 : 2'b10;
      out_cnt_reg <= out_cnt_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            w_base_reg  <= w_base;
            x_base_reg  <= x_base;
            x_len_reg   <= x_len;
            rd_cnt_reg  <= '0;
            out_cnt_reg <= '0;
            state_reg   <= LOAD_W;
          end
        end
        LOAD_W: begin
          if (!l0_full) begin
            if (rd_cnt_reg == addr_bw'(col - 1)) begin
              rd_cnt_reg <= '0;
              state_reg  <= GAP;
            end else begin
              rd_cnt_reg <= rd_cnt_reg + addr_bw'(1);
            end
          end
        end
        GAP: begin
          state_reg <= (x_len_reg != '0) ? EXEC : DONE;
        end
        EXEC: begin
          if (!l0_full) begin
            if (rd_cnt_reg == x_len_reg - addr_bw'(1)) begin
              rd_cnt_reg <= '0;
              state_reg  <= DRAIN;
            end else begin
              rd_cnt_reg <= rd_cnt_reg + addr_bw'(1);
            end
          end
        end
        DRAIN: begin
          if (out_cnt_next == x_len_reg)
            state_reg <= DONE;
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign l0_wr  = l0_wr_reg;
  assign inst_w = inst_w_reg;
  assign busy   = (state_reg != IDLE);
  assign done   = (state_reg == DONE);

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Scoreboard bench for mac_array_ctrl: stimulus queues expected reads, L0 writes
// and done cycles; a negedge monitor pops and compares whatever the DUT presents.
module tb_mac_array_ctrl;

  localparam int COL = 8;
  localparam int AW  = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] w_base;
  logic [AW-1:0] x_base;
  logic [AW-1:0] x_len;
  logic          l0_full;
  logic          out_valid;
  logic          mem_cen;
  logic [AW-1:0] mem_addr;
  logic          l0_wr;
  logic [1:0]    inst_w;
  logic          busy;
  logic          done;

  mac_array_ctrl #(.col(COL), .addr_bw(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .w_base    (w_base),
    .x_base    (x_base),
    .x_len     (x_len),
    .l0_full   (l0_full),
    .out_valid (out_valid),
    .mem_cen   (mem_cen),
    .mem_addr  (mem_addr),
    .l0_wr     (l0_wr),
    .inst_w    (inst_w),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  bit mon_en = 1'b0;

  logic [AW-1:0] exp_addr[$];
  logic [1:0]    exp_inst[$];
  int            exp_done[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: samples 2 time units after the falling edge, clear of input updates.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (!mem_cen) begin
        if (exp_addr.size() == 0) chk("unexpected_read", 32'(mem_addr), 32'hFFFF_FFFF);
        else chk("read_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
      end
      if (l0_wr) begin
        wr_count++;
        $display("cycle %0d: l0_wr inst_w=%b", cyc, inst_w);
        if (exp_inst.size() == 0) chk("unexpected_l0_wr", 32'(inst_w), 32'hFFFF_FFFF);
        else chk("inst_w", 32'(inst_w), 32'(exp_inst.pop_front()));
      end else begin
        chk("inst_w_idle", 32'(inst_w), 32'h0);
      end
      if (done) begin
        $display("cycle %0d: done", cyc);
        if (exp_done.size() == 0) chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
        else chk("done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
      end
    end
  end

  task automatic drain_check(input string tag);
    chk({tag, "_addr_left"}, 32'(exp_addr.size()), 32'h0);
    chk({tag, "_inst_left"}, 32'(exp_inst.size()), 32'h0);
    chk({tag, "_done_left"}, 32'(exp_done.size()), 32'h0);
    exp_addr.delete();
    exp_inst.delete();
    exp_done.delete();
  endtask

  // Cycle n is the period after the n-th edge counted from the start edge (edge 0).
  task automatic run_pass(input string tag,
                          input logic [AW-1:0] wb, input logic [AW-1:0] xb, input logic [AW-1:0] xl,
                          input int stall_c, input int stall_n,
                          input int v_first, input int v_step, input int v_n,
                          input int ign0, input int ign1, input int ign2,
                          input int done_c, input int end_c);
    int t0;
    @(negedge clk);
    wr_count = 0;
    for (int k = 0; k < COL; k++) begin
      exp_addr.push_back(wb + AW'(k));
      exp_inst.push_back(2'b01);
    end
    for (int j = 0; j < int'(xl); j++) begin
      exp_addr.push_back(xb + AW'(j));
      exp_inst.push_back(2'b10);
    end
    start = 1'b1; w_base = wb; x_base = xb; x_len = xl;
    t0 = cyc;
    exp_done.push_back(t0 + done_c);
    for (int c = 1; c <= end_c; c++) begin
      @(negedge clk);
      start     = (c == ign0) || (c == ign1) || (c == ign2);
      w_base    = start ? 11'h555 : wb;
      x_base    = start ? 11'h2AA : xb;
      x_len     = start ? 11'd2 : xl;
      l0_full   = (c >= stall_c) && (c < stall_c + stall_n);
      out_valid = (v_n > 0) && (c >= v_first) && ((c - v_first) % v_step == 0) &&
                  ((c - v_first) / v_step < v_n);
      #1;
      chk({tag, "_busy"}, 32'(busy), 32'(c <= done_c));
      if (l0_full) begin
        chk({tag, "_stall_cen"}, 32'(mem_cen), 32'h1);
        chk({tag, "_stall_addr"}, 32'(mem_addr), 32'(xb + AW'(stall_c - (COL + 2))));
      end
    end
    @(negedge clk);
    start = 1'b0; l0_full = 1'b0; out_valid = 1'b0;
    #3;
    chk({tag, "_wr_count"}, 32'(wr_count), 32'(COL + int'(xl)));
    drain_check(tag);
  endtask

  initial begin
    int t0;
    reset = 1'b1; start = 1'b0; w_base = '0; x_base = '0; x_len = '0;
    l0_full = 1'b0; out_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_cen", 32'(mem_cen), 32'h1);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_l0_wr", 32'(l0_wr), 32'h0);
    chk("rst_inst_w", 32'(inst_w), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    //        tag      wb      xb      xl  stall  v_first/step/n  ignored starts  done end
    run_pass("basic", 11'h010, 11'h100, 11'd4, 0, 0, 16, 3, 4, 0, 0, 0, 26, 30);
    run_pass("stall", 11'h010, 11'h100, 11'd4, 12, 3, 18, 1, 4, 0, 0, 0, 22, 26);
    run_pass("empty", 11'h020, 11'h300, 11'd0, 0, 0, 0, 1, 0, 0, 0, 0, 10, 14);
    run_pass("ignore", 11'h040, 11'h200, 11'd4, 0, 0, 10, 1, 6, 3, 14, 15, 15, 19);

    // Reset while EXEC is issuing j=1: that read's L0 write must be dropped.
    @(negedge clk);
    for (int k = 0; k < COL; k++) begin
      exp_addr.push_back(11'h010 + AW'(k));
      exp_inst.push_back(2'b01);
    end
    exp_addr.push_back(11'h100);
    exp_addr.push_back(11'h101);
    exp_inst.push_back(2'b10);
    start = 1'b1; w_base = 11'h010; x_base = 11'h100; x_len = 11'd4;
    t0 = cyc;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 11) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_mem_cen", 32'(mem_cen), 32'h1);
    chk("midrst_mem_addr", 32'(mem_addr), 32'h0);
    chk("midrst_l0_wr", 32'(l0_wr), 32'h0);
    chk("midrst_inst_w", 32'(inst_w), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    #3;
    drain_check("midrst");

    run_pass("after_rst", 11'h010, 11'h100, 11'd4, 0, 0, 16, 3, 4, 0, 0, 0, 26, 30);
    run_pass("wrap", 11'h000, 11'h7FE, 11'd4, 0, 0, 15, 1, 4, 0, 0, 0, 19, 23);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
